id_stage: RTL and testbench
===========================

Name: id_stage

Overview:
- Instruction-decode stage of the 5-stage MIPS pipeline, sitting directly upstream of the register file.
- Holds the IF/ID pipeline register and drives the register file read addresses rs/rt combinationally from it. The register file's registered dout_A/dout_B therefore arrive aligned with this block's ID/EX outputs.
- Decodes opcode/funct into ID/EX control, detects load-use hazards (one-cycle stall plus bubble), and squashes on branch flush.

Parameters:
- NOP_INSTR, 32'h0000_0000, instruction value loaded into IF/ID on reset or flush.
- PC_W, 32, width of the pc+4 path.

Ports:
- clk  in  1  pipeline clock; all state updates on posedge.
- rst  in  1  reset, asynchronous, active-low; clears all state.
- if_valid  in  1  IF presents a valid instruction this cycle.
- if_instr  in  32  fetched instruction.
- if_pc4  in  PC_W  pc+4 of the fetched instruction.
- flush  in  1  taken branch/jump resolved in EX; squash IF/ID and ID/EX.
- stall_o  out  1  combinational; IF must hold its PC and instruction.
- rs  out  5  register file read address A = IF/ID instr[25:21].
- rt  out  5  register file read address B = IF/ID instr[20:16].
- ex_valid  out  1  ID/EX holds a real instruction.
- ex_rs, ex_rt  out  5 each  source register numbers, for forwarding.
- ex_rd  out  5  writeback destination.
- ex_w_rb  out  1  register write enable for writeback.
- ex_mem_read  out  1  load.
- ex_mem_write  out  1  store.
- ex_branch  out  1  beq.
- ex_jump  out  1  j.
- ex_alu_op  out  3  0=ADD, 1=SUB, 2=AND, 3=OR, 4=SLT.
- ex_alu_src  out  1  1 = ALU B operand is the immediate.
- ex_imm  out  32  sign-extended instr[15:0].
- ex_jtarget  out  26  instr[25:0].
- ex_pc4  out  PC_W  pc+4 passed through.
- illegal_o  out  1  one-cycle pulse when an unsupported opcode/funct enters ID/EX.

Behaviour:
- Reset (rst=0, asynchronous):
  - IF/ID: instr=NOP_INSTR, valid=0, pc4=0.
  - Every ex_* output is 0 and illegal_o=0.
  - stall_o=0, because ex_valid=0.
- Latency: an instruction accepted into IF/ID at edge N appears on ex_* at edge N+1, the same edge the register file registers dout_A/dout_B.
- Decode:
  - R-type (op 000000), funct add 100000 / sub 100010 / and 100100 / or 100101 / slt 101010: rd=instr[15:11], w_rb=1, alu_src=0.
  - addi 001000: rd=instr[20:16], w_rb=1, ADD, alu_src=1.
  - lw 100011: rd=instr[20:16], w_rb=1, mem_read=1, ADD, alu_src=1.
  - sw 101011: w_rb=0, rd=0, mem_write=1, ADD, alu_src=1.
  - beq 000100: branch=1, SUB, alu_src=0, w_rb=0.
  - j 000010: jump=1, w_rb=0.
  - A computed rd of 0 forces w_rb=0; writes to $0 are never issued.
  - Unsupported opcode or funct: ID/EX gets a bubble and illegal_o=1 for one cycle. An all-zero instruction (sll $0) is a NOP and is not illegal.
- Bubble: ex_valid, ex_w_rb, ex_mem_read, ex_mem_write, ex_branch and ex_jump all 0. The remaining ex_* fields are don't-care but driven to 0.
- Load-use hazard: hz = ex_valid & ex_mem_read & (ex_rd!=0) & ((ex_rd==rs & uses_rs) | (ex_rd==rt & uses_rt)).
  - uses_rs: R-type, addi, lw, sw, beq.
  - uses_rt: R-type, sw, beq.
  - Only evaluated when the IF/ID entry is valid.
  - stall_o=hz. On the edge: IF/ID holds, and ID/EX receives a bubble.
  - A stall always lasts exactly one cycle, since the bubble clears hz.
- Flush: at the next edge IF/ID loads NOP_INSTR with valid=0, and ID/EX receives a bubble.
  - Flush overrides stall and if_valid.
  - stall_o is masked to 0 while flush=1.
- IF/ID update when neither stall nor flush: load if_instr/if_pc4 and valid=if_valid. if_valid=0 loads a bubble.
- rs/rt are always driven from IF/ID, including during a stall, so the register file re-reads the same addresses.
- Reset asserted mid-stall or mid-flush: the stall/flush state is discarded. After release, the first instruction is accepted on the first edge.

Test Plan:
- Reset: hold rst=0, drive if_valid=1 with add $3,$1,$2 -> all ex_* =0 and stall_o=0; release rst, next edge -> rs=1, rt=2; one edge later -> ex_rd=3, ex_w_rb=1, ex_alu_op=0.
- I-type decode: lw $5,-4($6) (0x8CC5FFFC) -> ex_rd=5, ex_mem_read=1, ex_alu_src=1, ex_imm=0xFFFFFFFC; sw $5,8($6) -> ex_w_rb=0, ex_mem_write=1, ex_imm=8.
- Load-use: lw $5,0($6) followed by add $7,$5,$1 -> stall_o=1 for exactly one cycle, ID/EX bubble (ex_valid=0), then add issues with ex_rs=5; lw $0 then add $7,$0,$1 -> no stall.
- Flush priority: flush=1 in the same cycle as a load-use hazard -> stall_o=0; next edge IF/ID instr=NOP_INSTR, ex_valid=0.
- Write-to-$0: addi $0,$1,5 -> ex_rd=0, ex_w_rb=0, ex_valid=1.
- Illegal: opcode 111111 -> illegal_o pulses one cycle, ex_valid=0; following valid instruction decodes normally.

Source files
------------

// File: rtl/id_stage.sv
`default_nettype none
// id_stage: MIPS IF/ID register, opcode decode and ID/EX register with load-use stall and flush.
// Rev 1.0
module id_stage #(
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000,
  parameter int unsigned PC_W      = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_valid,
  input  logic [31:0]     if_instr,
  input  logic [PC_W-1:0] if_pc4,
  input  logic            flush,
  output logic            stall_o,
  output logic [4:0]      rs,
  output logic [4:0]      rt,
  output logic            ex_valid,
  output logic [4:0]      ex_rs,
  output logic [4:0]      ex_rt,
  output logic [4:0]      ex_rd,
  output logic            ex_w_rb,
  output logic            ex_mem_read,
  output logic            ex_mem_write,
  output logic            ex_branch,
  output logic            ex_jump,
  output logic [2:0]      ex_alu_op,
  output logic            ex_alu_src,
  output logic [31:0]     ex_imm,
  output logic [25:0]     ex_jtarget,
  output logic [PC_W-1:0] ex_pc4,
  output logic            illegal_o
);

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;
  localparam logic [2:0] ALU_SLT = 3'd4;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  // IF/ID pipeline register
  logic [31:0]     ifid_instr_q, ifid_instr_d;
  logic            ifid_valid_q, ifid_valid_d;
  logic [PC_W-1:0] ifid_pc4_q,   ifid_pc4_d;

  // ID/EX pipeline register
  logic            ex_valid_q,     ex_valid_d;
  logic [4:0]      ex_rs_q,        ex_rs_d;
  logic [4:0]      ex_rt_q,        ex_rt_d;
  logic [4:0]      ex_rd_q,        ex_rd_d;
  logic            ex_w_rb_q,      ex_w_rb_d;
  logic            ex_mem_read_q,  ex_mem_read_d;
  logic            ex_mem_write_q, ex_mem_write_d;
  logic            ex_branch_q,    ex_branch_d;
  logic            ex_jump_q,      ex_jump_d;
  logic [2:0]      ex_alu_op_q,    ex_alu_op_d;
  logic            ex_alu_src_q,   ex_alu_src_d;
  logic [31:0]     ex_imm_q,       ex_imm_d;
  logic [25:0]     ex_jtarget_q,   ex_jtarget_d;
  logic [PC_W-1:0] ex_pc4_q,       ex_pc4_d;
  logic            illegal_q,      illegal_d;

  // Decode results for the instruction currently in IF/ID
  logic [5:0] dec_op;
  logic [5:0] dec_funct;
  logic [4:0] dec_rs;
  logic [4:0] dec_rt;
  logic       dec_legal;
  logic [4:0] dec_rd;
  logic       dec_w_rb;
  logic       dec_mem_read;
  logic       dec_mem_write;
  logic       dec_branch;
  logic       dec_jump;
  logic [2:0] dec_alu_op;
  logic       dec_alu_src;
  logic       dec_uses_rs;
  logic       dec_uses_rt;
  logic       hz;
  logic       issue;

  assign dec_op    = ifid_instr_q[31:26];
  assign dec_funct = ifid_instr_q[5:0];
  assign dec_rs    = ifid_instr_q[25:21];
  assign dec_rt    = ifid_instr_q[20:16];

  always_comb begin
    dec_legal     = 1'b0;
    dec_rd        = 5'd0;
    dec_w_rb      = 1'b0;
    dec_mem_read  = 1'b0;
    dec_mem_write = 1'b0;
    dec_branch    = 1'b0;
    dec_jump      = 1'b0;
    dec_alu_op    = ALU_ADD;
    dec_alu_src   = 1'b0;
    dec_uses_rs   = 1'b0;
    dec_uses_rt   = 1'b0;
    case (dec_op)
      OP_RTYPE: begin
        dec_rd      = ifid_instr_q[15:11];
        dec_w_rb    = 1'b1;
        dec_uses_rs = 1'b1;
        dec_uses_rt = 1'b1;
        case (dec_funct)
          FN_ADD: begin dec_legal = 1'b1; dec_alu_op = ALU_ADD; end
          FN_SUB: begin dec_legal = 1'b1; dec_alu_op = ALU_SUB; end
          FN_AND: begin dec_legal = 1'b1; dec_alu_op = ALU_AND; end
          FN_OR:  begin dec_legal = 1'b1; dec_alu_op = ALU_OR;  end
          FN_SLT: begin dec_legal = 1'b1; dec_alu_op = ALU_SLT; end
          // Only the canonical all-zero sll is accepted, as a NOP
          default: dec_legal = (ifid_instr_q == 32'h0000_0000);
        endcase
      end
      OP_ADDI: begin
        dec_legal   = 1'b1;
        dec_rd      = dec_rt;
        dec_w_rb    = 1'b1;
        dec_alu_src = 1'b1;
        dec_uses_rs = 1'b1;
      end
      OP_LW: begin
        dec_legal    = 1'b1;
        dec_rd       = dec_rt;
        dec_w_rb     = 1'b1;
        dec_mem_read = 1'b1;
        dec_alu_src  = 1'b1;
        dec_uses_rs  = 1'b1;
      end
      OP_SW: begin
        dec_legal     = 1'b1;
        dec_mem_write = 1'b1;
        dec_alu_src   = 1'b1;
        dec_uses_rs   = 1'b1;
        dec_uses_rt   = 1'b1;
      end
      OP_BEQ: begin
        dec_legal   = 1'b1;
        dec_branch  = 1'b1;
        dec_alu_op  = ALU_SUB;
        dec_uses_rs = 1'b1;
        dec_uses_rt = 1'b1;
      end
      OP_J: begin
        dec_legal = 1'b1;
        dec_jump  = 1'b1;
      end
      default: dec_legal = 1'b0;
    endcase
  end

  // Load-use hazard against the load sitting in ID/EX
  assign hz = ifid_valid_q & dec_legal & ex_valid_q & ex_mem_read_q & (ex_rd_q != 5'd0)
            & (((ex_rd_q == dec_rs) & dec_uses_rs) | ((ex_rd_q == dec_rt) & dec_uses_rt));

  assign stall_o = hz & ~flush;
  assign issue   = ifid_valid_q & dec_legal & ~flush & ~hz;

  always_comb begin
    ifid_instr_d = ifid_instr_q;
    ifid_valid_d = ifid_valid_q;
    ifid_pc4_d   = ifid_pc4_q;
    if (flush || (!hz && !if_valid)) begin
      ifid_instr_d = NOP_INSTR;
      ifid_valid_d = 1'b0;
      ifid_pc4_d   = '0;
    end else if (!hz) begin
      ifid_instr_d = if_instr;
      ifid_valid_d = 1'b1;
      ifid_pc4_d   = if_pc4;
    end
  end

  always_comb begin
    ex_valid_d     = 1'b0;
    ex_rs_d        = 5'd0;
    ex_rt_d        = 5'd0;
    ex_rd_d        = 5'd0;
    ex_w_rb_d      = 1'b0;
    ex_mem_read_d  = 1'b0;
    ex_mem_write_d = 1'b0;
    ex_branch_d    = 1'b0;
    ex_jump_d      = 1'b0;
    ex_alu_op_d    = ALU_ADD;
    ex_alu_src_d   = 1'b0;
    ex_imm_d       = 32'd0;
    ex_jtarget_d   = 26'd0;
    ex_pc4_d       = '0;
    illegal_d      = ifid_valid_q & ~dec_legal & ~flush;
    if (issue) begin
      ex_valid_d     = 1'b1;
      ex_rs_d        = dec_rs;
      ex_rt_d        = dec_rt;
      ex_rd_d        = dec_rd;
      // A write to $0 is never issued
      ex_w_rb_d      = dec_w_rb & (dec_rd != 5'd0);
      ex_mem_read_d  = dec_mem_read;
      ex_mem_write_d = dec_mem_write;
      ex_branch_d    = dec_branch;
      ex_jump_d      = dec_jump;
      ex_alu_op_d    = dec_alu_op;
      ex_alu_src_d   = dec_alu_src;
      ex_imm_d       = {{16{ifid_instr_q[15]}}, ifid_instr_q[15:0]};
      ex_jtarget_d   = ifid_instr_q[25:0];
      ex_pc4_d       = ifid_pc4_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ifid_instr_q   <= NOP_INSTR;
      ifid_valid_q   <= 1'b0;
      ifid_pc4_q     <= '0;
      ex_valid_q     <= 1'b0;
      ex_rs_q        <= 5'd0;
      ex_rt_q        <= 5'd0;
      ex_rd_q        <= 5'd0;
      ex_w_rb_q      <= 1'b0;
      ex_mem_read_q  <= 1'b0;
      ex_mem_write_q <= 1'b0;
      ex_branch_q    <= 1'b0;
      ex_jump_q      <= 1'b0;
      ex_alu_op_q    <= 3'd0;
      ex_alu_src_q   <= 1'b0;
      ex_imm_q       <= 32'd0;
      ex_jtarget_q   <= 26'd0;
      ex_pc4_q       <= '0;
      illegal_q      <= 1'b0;
    end else begin
      ifid_instr_q   <= ifid_instr_d;
      ifid_valid_q   <= ifid_valid_d;
      ifid_pc4_q     <= ifid_pc4_d;
      ex_valid_q     <= ex_valid_d;
      ex_rs_q        <= ex_rs_d;
      ex_rt_q        <= ex_rt_d;
      ex_rd_q        <= ex_rd_d;
      ex_w_rb_q      <= ex_w_rb_d;
      ex_mem_read_q  <= ex_mem_read_d;
      ex_mem_write_q <= ex_mem_write_d;
      ex_branch_q    <= ex_branch_d;
      ex_jump_q      <= ex_jump_d;
      ex_alu_op_q    <= ex_alu_op_d;
      ex_alu_src_q   <= ex_alu_src_d;
      ex_imm_q       <= ex_imm_d;
      ex_jtarget_q   <= ex_jtarget_d;
      ex_pc4_q       <= ex_pc4_d;
      illegal_q      <= illegal_d;
    end
  end

  assign rs           = dec_rs;
  assign rt           = dec_rt;
  assign ex_valid     = ex_valid_q;
  assign ex_rs        = ex_rs_q;
  assign ex_rt        = ex_rt_q;
  assign ex_rd        = ex_rd_q;
  assign ex_w_rb      = ex_w_rb_q;
  assign ex_mem_read  = ex_mem_read_q;
  assign ex_mem_write = ex_mem_write_q;
  assign ex_branch    = ex_branch_q;
  assign ex_jump      = ex_jump_q;
  assign ex_alu_op    = ex_alu_op_q;
  assign ex_alu_src   = ex_alu_src_q;
  assign ex_imm       = ex_imm_q;
  assign ex_jtarget   = ex_jtarget_q;
  assign ex_pc4       = ex_pc4_q;
  assign illegal_o    = illegal_q;

endmodule
`default_nettype wire

// File: tb/tb_id_stage.sv
`default_nettype none
// tb_id_stage: directed vectors for id_stage, checked through an expected-output queue.
// Rev 1.0
module tb_id_stage;

  typedef struct packed {
    logic        stall;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic        v;
    logic [4:0]  xrs;
    logic [4:0]  xrt;
    logic [4:0]  xrd;
    logic        wrb;
    logic        mr;
    logic        mw;
    logic        br;
    logic        jp;
    logic [2:0]  alu;
    logic        src;
    logic [31:0] imm;
    logic [25:0] jt;
    logic [31:0] pc4;
    logic        ill;
  } obs_t;

  logic        clk;
  logic        rst;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc4;
  logic        flush;
  logic        stall_o;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic        ex_valid;
  logic [4:0]  ex_rs;
  logic [4:0]  ex_rt;
  logic [4:0]  ex_rd;
  logic        ex_w_rb;
  logic        ex_mem_read;
  logic        ex_mem_write;
  logic        ex_branch;
  logic        ex_jump;
  logic [2:0]  ex_alu_op;
  logic        ex_alu_src;
  logic [31:0] ex_imm;
  logic [25:0] ex_jtarget;
  logic [31:0] ex_pc4;
  logic        illegal_o;

  id_stage #(.NOP_INSTR(32'h0000_0000), .PC_W(32)) dut (
    .clk(clk), .rst(rst), .if_valid(if_valid), .if_instr(if_instr), .if_pc4(if_pc4),
    .flush(flush), .stall_o(stall_o), .rs(rs), .rt(rt), .ex_valid(ex_valid),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_w_rb(ex_w_rb),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_branch(ex_branch),
    .ex_jump(ex_jump), .ex_alu_op(ex_alu_op), .ex_alu_src(ex_alu_src), .ex_imm(ex_imm),
    .ex_jtarget(ex_jtarget), .ex_pc4(ex_pc4), .illegal_o(illegal_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  obs_t  exp_q[$];
  string name_q[$];
  int    n_cmp = 0;
  int    n_bad = 0;

  localparam obs_t BUB = '0;

  function automatic obs_t exf(input logic v, input logic [4:0] xrs, input logic [4:0] xrt,
                               input logic [4:0] xrd, input logic wrb, input logic mr,
                               input logic mw, input logic br, input logic jp,
                               input logic [2:0] alu, input logic src, input logic [31:0] imm,
                               input logic [25:0] jt, input logic [31:0] pc4);
    obs_t o;
    o = '0;
    o.v = v; o.xrs = xrs; o.xrt = xrt; o.xrd = xrd; o.wrb = wrb; o.mr = mr; o.mw = mw;
    o.br = br; o.jp = jp; o.alu = alu; o.src = src; o.imm = imm; o.jt = jt; o.pc4 = pc4;
    return o;
  endfunction

  // Drive one cycle of inputs and queue the outputs expected during that cycle
  task automatic step(input string nm, input logic r, input logic v, input logic [31:0] ins,
                      input logic [31:0] pc, input logic fl, input obs_t ex,
                      input logic [4:0] ers, input logic [4:0] ert, input logic est,
                      input logic eill);
    obs_t e;
    rst = r; if_valid = v; if_instr = ins; if_pc4 = pc; flush = fl;
    e = ex;
    e.rs = ers; e.rt = ert; e.stall = est; e.ill = eill;
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      obs_t  e;
      obs_t  a;
      string nm;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      a  = '{stall_o, rs, rt, ex_valid, ex_rs, ex_rt, ex_rd, ex_w_rb, ex_mem_read,
             ex_mem_write, ex_branch, ex_jump, ex_alu_op, ex_alu_src, ex_imm, ex_jtarget,
             ex_pc4, illegal_o};
      n_cmp = n_cmp + 1;
      if (a !== e) begin
        n_bad = n_bad + 1;
        $display("FAIL %s: got %h expected %h", nm, a, e);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  localparam logic [31:0] ADD3  = 32'h0022_1820;
  localparam logic [31:0] LWM4  = 32'h8CC5_FFFC;
  localparam logic [31:0] SW8   = 32'hACC5_0008;
  localparam logic [31:0] ADDI0 = 32'h2020_0005;
  localparam logic [31:0] LW5   = 32'h8CC5_0000;
  localparam logic [31:0] ADD7  = 32'h00A1_3820;
  localparam logic [31:0] LW0   = 32'h8CC0_0000;
  localparam logic [31:0] ADD70 = 32'h0001_3820;
  localparam logic [31:0] ILL   = 32'hFC00_0000;
  localparam logic [31:0] SUB4  = 32'h0043_2022;
  localparam logic [31:0] BEQ   = 32'h1022_0003;
  localparam logic [31:0] JMP   = 32'h0800_0010;

  initial begin
    rst = 1'b0; if_valid = 1'b0; if_instr = 32'd0; if_pc4 = 32'd0; flush = 1'b0;
    @(posedge clk);
    #1;
    //    name          rst v  instr  pc4      fl expected ID/EX fields                                                      rs     rt    stall ill
    step("reset0",     0, 1, ADD3,  32'h104, 0, BUB,                                                                          5'd0, 5'd0, 0, 0);
    step("reset1",     0, 1, ADD3,  32'h104, 0, BUB,                                                                          5'd0, 5'd0, 0, 0);
    step("release",    1, 1, ADD3,  32'h104, 0, BUB,                                                                          5'd0, 5'd0, 0, 0);
    step("ifid_add",   1, 1, LWM4,  32'h108, 0, BUB,                                                                          5'd1, 5'd2, 0, 0);
    step("ex_add",     1, 1, SW8,   32'h10C, 0, exf(1,5'd1,5'd2,5'd3,1,0,0,0,0,3'd0,0,32'h00001820,26'h0221820,32'h104), 5'd6, 5'd5, 0, 0);
    step("ex_lw_neg",  1, 1, ADDI0, 32'h110, 0, exf(1,5'd6,5'd5,5'd5,1,1,0,0,0,3'd0,1,32'hFFFFFFFC,26'h0C5FFFC,32'h108), 5'd6, 5'd5, 1, 0);
    step("sw_bubble",  1, 1, ADDI0, 32'h110, 0, BUB,                                                                          5'd6, 5'd5, 0, 0);
    step("ex_sw",      1, 1, LW5,   32'h114, 0, exf(1,5'd6,5'd5,5'd0,0,0,1,0,0,3'd0,1,32'h00000008,26'h0C50008,32'h10C), 5'd1, 5'd0, 0, 0);
    step("ex_addi0",   1, 1, ADD7,  32'h118, 0, exf(1,5'd1,5'd0,5'd0,0,0,0,0,0,3'd0,1,32'h00000005,26'h0200005,32'h110), 5'd6, 5'd5, 0, 0);
    step("lu_stall",   1, 1, LW0,   32'h11C, 0, exf(1,5'd6,5'd5,5'd5,1,1,0,0,0,3'd0,1,32'h00000000,26'h0C50000,32'h114), 5'd5, 5'd1, 1, 0);
    step("lu_bubble",  1, 1, LW0,   32'h11C, 0, BUB,                                                                          5'd5, 5'd1, 0, 0);
    step("ex_add_rs5", 1, 1, ADD70, 32'h120, 0, exf(1,5'd5,5'd1,5'd7,1,0,0,0,0,3'd0,0,32'h00003820,26'h0A13820,32'h118), 5'd6, 5'd0, 0, 0);
    step("lw0_nostal", 1, 1, ILL,   32'h124, 0, exf(1,5'd6,5'd0,5'd0,0,1,0,0,0,3'd0,1,32'h00000000,26'h0C00000,32'h11C), 5'd0, 5'd1, 0, 0);
    step("ex_add_rs0", 1, 1, SUB4,  32'h128, 0, exf(1,5'd0,5'd1,5'd7,1,0,0,0,0,3'd0,0,32'h00003820,26'h0013820,32'h120), 5'd0, 5'd0, 0, 0);
    step("illegal",    1, 1, LW5,   32'h12C, 0, BUB,                                                                          5'd2, 5'd3, 0, 1);
    step("ex_sub",     1, 1, ADD7,  32'h130, 0, exf(1,5'd2,5'd3,5'd4,1,0,0,0,0,3'd1,0,32'h00002022,26'h0432022,32'h128), 5'd6, 5'd5, 0, 0);
    step("flush_mask", 1, 1, BEQ,   32'h134, 1, exf(1,5'd6,5'd5,5'd5,1,1,0,0,0,3'd0,1,32'h00000000,26'h0C50000,32'h12C), 5'd5, 5'd1, 0, 0);
    step("flushed",    1, 1, BEQ,   32'h134, 0, BUB,                                                                          5'd0, 5'd0, 0, 0);
    step("ifid_beq",   1, 1, JMP,   32'h138, 0, BUB,                                                                          5'd1, 5'd2, 0, 0);
    step("ex_beq",     1, 0, 32'hDEADBEEF, 32'h13C, 0, exf(1,5'd1,5'd2,5'd0,0,0,0,1,0,3'd1,0,32'h00000003,26'h0220003,32'h134), 5'd0, 5'd0, 0, 0);
    step("ex_j",       1, 0, 32'd0, 32'h0,   0, exf(1,5'd0,5'd0,5'd0,0,0,0,0,1,3'd0,0,32'h00000010,26'h0000010,32'h138), 5'd0, 5'd0, 0, 0);
    step("idle",       1, 0, 32'd0, 32'h0,   0, BUB,                                                                          5'd0, 5'd0, 0, 0);
    step("pre_lw",     1, 1, LW5,   32'h200, 0, BUB,                                                                          5'd0, 5'd0, 0, 0);
    step("pre_add",    1, 1, ADD7,  32'h204, 0, BUB,                                                                          5'd6, 5'd5, 0, 0);
    step("rst_mid",    0, 1, ADD7,  32'h204, 0, BUB,                                                                          5'd0, 5'd0, 0, 0);
    step("rst_rel",    1, 1, ADD7,  32'h204, 0, BUB,                                                                          5'd0, 5'd0, 0, 0);
    step("post_ifid",  1, 0, 32'd0, 32'h0,   0, BUB,                                                                          5'd5, 5'd1, 0, 0);
    step("post_ex",    1, 0, 32'd0, 32'h0,   0, exf(1,5'd5,5'd1,5'd7,1,0,0,0,0,3'd0,0,32'h00003820,26'h0A13820,32'h204), 5'd0, 5'd0, 0, 0);
    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
        n_bad = n_bad + 1;
        $display("FAIL drain: %0d expected entries never compared", exp_q.size());
    end
    if (n_cmp != 28) begin
        n_bad = n_bad + 1;
        $display("FAIL count: %0d comparisons made, expected 28", n_cmp);
    end
    if (n_bad != 0) begin
        $display("FAIL total: %0d mismatches", n_bad);
    end else begin
        $display("PASS all %0d comparisons", n_cmp);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
